// File: rtl/skin_pkg.sv
// Shared definitions for the binary skin-segmentation stream blocks:
// coordinate width, test-pattern encodings, FSM state codes and the pixel function.
package skin_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    PAT_ZERO  = 2'd0,
    PAT_ONE   = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_DOTS  = 2'd3
  } pattern_e;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Checkerboard squares are 4x4; dots sit at (3,3) of every 8x8 tile so a 5x5 median removes them.
  function automatic logic pixel_value(input logic [1:0] pat,
                                       input logic [2:0] h_lo,
                                       input logic [2:0] v_lo);
    logic val;
    val = 1'b0;
    case (pat)
      PAT_ZERO:  val = 1'b0;
      PAT_ONE:   val = 1'b1;
      PAT_CHECK: val = h_lo[2] ^ v_lo[2];
      PAT_DOTS:  val = (h_lo == 3'd3) && (v_lo == 3'd3);
      default:   val = 1'b0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/frame_timing_gen.sv
// Horizontal/vertical raster counters with combinational region decode
// (active video, hsync, vsync) and a last-cycle-of-frame flag.
import skin_pkg::*;

module frame_timing_gen #(
  parameter int H_SIZE  = 83,
  parameter int V_SIZE  = 64,
  parameter int H_FRONT = 4,
  parameter int H_SYNC  = 8,
  parameter int H_BACK  = 8,
  parameter int V_FRONT = 2,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               last,
  output logic               de,
  output logic               hsync,
  output logic               vsync
);

  localparam int H_TOTAL = H_SIZE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_SIZE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_SIZE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_SIZE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_SIZE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_SIZE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_SIZE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_SIZE + V_FRONT + V_SYNC - 1);

  // Counters sit at (0,0) whenever not running, so a new frame always starts at the origin.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    de    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vsync = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  end

endmodule

// File: rtl/binary_frame_tx.sv
// Binary pixel stream source: run/idle control, per-frame pattern latching and
// a registered output stage aligning pixel, de, syncs and coordinates.
import skin_pkg::*;

module binary_frame_tx #(
  parameter int H_SIZE  = 83,
  parameter int V_SIZE  = 64,
  parameter int H_FRONT = 4,
  parameter int H_SYNC  = 8,
  parameter int H_BACK  = 8,
  parameter int V_FRONT = 2,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         pattern,
  output logic               binary,
  output logic               de,
  output logic               vsync,
  output logic               hsync,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start
);

  logic               state;
  logic [1:0]         pat_q;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               last;
  logic               t_de;
  logic               t_hsync;
  logic               t_vsync;

  frame_timing_gen #(
    .H_SIZE (H_SIZE),
    .V_SIZE (V_SIZE),
    .H_FRONT(H_FRONT),
    .H_SYNC (H_SYNC),
    .H_BACK (H_BACK),
    .V_FRONT(V_FRONT),
    .V_SYNC (V_SYNC),
    .V_BACK (V_BACK)
  ) u_timing (
    .clk  (clk),
    .rst  (rst),
    .run  (state == ST_RUN),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .last (last),
    .de   (t_de),
    .hsync(t_hsync),
    .vsync(t_vsync)
  );

  // Leaving RUN and resampling the pattern both happen only on the frame's last cycle,
  // so a frame is never truncated and never changes pattern part-way through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pat_q <= PAT_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_RUN;
            pat_q <= pattern;
          end
        end
        default: begin
          if (last) begin
            if (en) pat_q <= pattern;
            else    state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      binary      <= 1'b0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      binary      <= t_de && pixel_value(pat_q, h_cnt[2:0], v_cnt[2:0]);
      de          <= t_de;
      hsync       <= t_hsync;
      vsync       <= t_vsync;
      x           <= h_cnt;
      y           <= v_cnt;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_binary_frame_tx.sv
// Self-checking bench for binary_frame_tx: cycle scoreboard against a frame-phase model,
// frame statistics, a pixel table and hand-written reset / enable / pattern-change sequences.
module tb_binary_frame_tx;

  localparam int HT    = 103;
  localparam int VT    = 70;
  localparam int FRAME = HT * VT;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] pattern;
  logic       binary;
  logic       de;
  logic       vsync;
  logic       hsync;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;

  int total  = 0;
  int passed = 0;

  binary_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pattern    (pattern),
    .binary     (binary),
    .de         (de),
    .vsync      (vsync),
    .hsync      (hsync),
    .x          (x),
    .y          (y),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [24:0] dutVec();
    return {frame_start, binary, de, vsync, hsync, x, y};
  endfunction

  // Reference outputs for frame phase p (p = v*HT + h) under pattern pat.
  function automatic logic [24:0] expVec(input int p, input logic [1:0] pat);
    int h, v;
    logic a, b;
    h = p % HT;
    v = p / HT;
    a = (h < 83) && (v < 64);
    case (pat)
      2'd0:    b = 1'b0;
      2'd1:    b = 1'b1;
      2'd2:    b = (((h / 4) + (v / 4)) % 2) == 1;
      default: b = (h % 8 == 3) && (v % 8 == 3);
    endcase
    return {p == 0, a && b, a, (v >= 66) && (v <= 67), (h >= 87) && (h <= 94), 10'(h), 10'(v)};
  endfunction

  logic [24:0] sb[$];
  logic        mRun = 1'b0;
  int          mPhase = 0;
  logic [1:0]  mPat = 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      sb.push_back('0);
      mRun = 1'b0; mPhase = 0; mPat = 2'd0;
    end else if (!mRun) begin
      sb.push_back('0);
      if (en) begin mRun = 1'b1; mPhase = 0; mPat = pattern; end
    end else begin
      sb.push_back(expVec(mPhase, mPat));
      if (mPhase == FRAME - 1) begin
        mPhase = 0;
        if (en) mPat = pattern;
        else    mRun = 1'b0;
      end else begin
        mPhase++;
      end
    end
  end

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput("scoreboard", dutVec(), sb.pop_front());
  end

  int stOnes, stOnesOff, stHsHigh, stHsRises, stHsFirstX, stVsMin, stVsMax, stPeriod;

  task automatic waitXY(input int wx, input int wy, input int budget);
    int n = 0;
    while (!(x == 10'(wx) && y == 10'(wy)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("reach_%0d_%0d", wx, wy), (x == 10'(wx)) && (y == 10'(wy)), 1);
  endtask

  // Gathers one whole frame from frame_start to the next; nextPat is driven once the frame begins.
  task automatic applyStimulus(input logic [1:0] nextPat);
    int n = 0;
    logic prevHs = 1'b0;
    while (!frame_start && n < 2 * FRAME) begin @(negedge clk); n++; end
    checkOutput("frame_start_seen", frame_start, 1);
    pattern = nextPat;
    stOnes = 0; stOnesOff = 0; stHsHigh = 0; stHsRises = 0;
    stHsFirstX = -1; stVsMin = 999; stVsMax = -1; n = 0;
    do begin
      if (binary && de)  stOnes++;
      if (binary && !de) stOnesOff++;
      if (hsync) stHsHigh++;
      if (hsync && !prevHs) begin
        stHsRises++;
        if (stHsFirstX < 0) stHsFirstX = int'(x);
      end
      prevHs = hsync;
      if (vsync) begin
        if (int'(y) < stVsMin) stVsMin = int'(y);
        if (int'(y) > stVsMax) stVsMax = int'(y);
      end
      @(negedge clk);
      n++;
    end while (!frame_start && n < FRAME + 100);
    stPeriod = n;
  endtask

  typedef struct {
    logic [1:0] pat;
    int         px;
    int         py;
    logic       expBin;
  } pix_vec_t;

  pix_vec_t tbl[12];

  task automatic runTable(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pattern = tbl[i].pat;
      waitXY(tbl[i].px, tbl[i].py, FRAME);
      checkOutput($sformatf("pix_p%0d_%0d_%0d", tbl[i].pat, tbl[i].px, tbl[i].py), binary, tbl[i].expBin);
    end
  endtask

  initial begin
    int checkOnes;
    int cnt;
    tbl[0]  = '{2'd2, 0, 0, 1'b0};
    tbl[1]  = '{2'd2, 4, 0, 1'b1};
    tbl[2]  = '{2'd2, 85, 0, 1'b0};
    tbl[3]  = '{2'd2, 0, 4, 1'b1};
    tbl[4]  = '{2'd2, 4, 4, 1'b0};
    tbl[5]  = '{2'd3, 3, 3, 1'b1};
    tbl[6]  = '{2'd3, 4, 3, 1'b0};
    tbl[7]  = '{2'd3, 11, 3, 1'b1};
    tbl[8]  = '{2'd3, 83, 3, 1'b0};
    tbl[9]  = '{2'd3, 3, 4, 1'b0};
    tbl[10] = '{2'd3, 3, 11, 1'b1};
    tbl[11] = '{2'd3, 75, 59, 1'b1};

    checkOnes = 0;
    for (int v = 0; v < 64; v++)
      for (int h = 0; h < 83; h++)
        if ((((h / 4) + (v / 4)) % 2) == 1) checkOnes++;

    rst = 1'b1; en = 1'b0; pattern = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", dutVec(), 0);
    rst = 1'b0;

    en = 1'b1; pattern = 2'd1;
    @(negedge clk);
    checkOutput("de_one_edge_after_en", de, 0);
    @(negedge clk);
    checkOutput("first_pixel", {frame_start, de, x, y}, {2'b11, 20'd0});

    applyStimulus(2'd2);
    checkOutput("p1_ones", stOnes, 5312);
    checkOutput("p1_ones_outside_de", stOnesOff, 0);
    checkOutput("hsync_high_cycles", stHsHigh, 8 * 70);
    checkOutput("hsync_pulses", stHsRises, 70);
    checkOutput("hsync_first_x", stHsFirstX, 87);
    checkOutput("vsync_first_line", stVsMin, 66);
    checkOutput("vsync_last_line", stVsMax, 67);
    checkOutput("frame_period", stPeriod, FRAME);

    runTable(0, 4);
    applyStimulus(2'd3);
    checkOutput("p2_ones", stOnes, checkOnes);
    checkOutput("p2_ones_outside_de", stOnesOff, 0);

    runTable(5, 11);
    applyStimulus(2'd0);
    checkOutput("p3_ones", stOnes, 80);
    checkOutput("p3_ones_outside_de", stOnesOff, 0);

    waitXY(20, 30, FRAME);
    pattern = 2'd1;
    cnt = 0;
    for (int n = 0; n < FRAME && !frame_start; n++) begin
      if (binary) cnt++;
      @(negedge clk);
    end
    checkOutput("midframe_pattern_ones", cnt, 0);
    checkOutput("new_pattern_at_origin", {frame_start, binary}, 2'b11);

    waitXY(40, 10, FRAME);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_midframe", dutVec(), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("de_low_after_reset", de, 0);
    @(negedge clk);
    checkOutput("restart_after_reset", {frame_start, de, x, y}, {2'b11, 20'd0});

    waitXY(10, 5, FRAME);
    en = 1'b0;
    waitXY(102, 69, FRAME);
    @(negedge clk);
    checkOutput("idle_after_last", dutVec(), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (dutVec() != 0) cnt++;
    end
    checkOutput("stays_idle", cnt, 0);

    en = 1'b1;
    @(negedge clk);
    checkOutput("de_low_on_reenable", de, 0);
    @(negedge clk);
    checkOutput("reenable_origin", {frame_start, de, x, y}, {2'b11, 20'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/binary_frame_tx.md
Name: binary_frame_tx

Overview:
- Transmit end of the binary pixel stream interface (binary, de, vsync, hsync) consumed by the skin-segmentation post-filters, e.g. the 5x5 median.
- Generates frame timing with H_SIZE active pixels per line and V_SIZE active lines, plus a selectable binary test pattern.
- Used as an on-chip stimulus source and bring-up driver in place of the colour-threshold front end.

Parameters:
- H_SIZE, 83, active pixels per line (10-bit)
- V_SIZE, 64, active lines per frame (10-bit)
- H_FRONT, 4, horizontal front porch, cycles
- H_SYNC, 8, hsync width, cycles
- H_BACK, 8, horizontal back porch, cycles
- V_FRONT, 2, vertical front porch, lines
- V_SYNC, 2, vsync width, lines
- V_BACK, 2, vertical back porch, lines

Ports:
- clk  in  1  pixel clock, one pixel per cycle
- rst  in  1  synchronous reset, active-high
- en  in  1  frame generation enable
- pattern  in  2  0=all 0, 1=all 1, 2=checkerboard, 3=isolated dots
- binary  out  1  pixel value, valid when de=1
- de  out  1  active-video flag
- vsync  out  1  vertical sync, active-high
- hsync  out  1  horizontal sync, active-high
- x  out  10  column of current pixel, 0..H_TOTAL-1
- y  out  10  row of current pixel, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)

Behaviour:
- Derived sizes: H_TOTAL=H_SIZE+H_FRONT+H_SYNC+H_BACK (103 at defaults); V_TOTAL=V_SIZE+V_FRONT+V_SYNC+V_BACK (70); frame = 7210 cycles.
- Horizontal regions of h_cnt: active 0..H_SIZE-1; front porch; then hsync=1 for h_cnt in [H_SIZE+H_FRONT, H_SIZE+H_FRONT+H_SYNC-1]; then back porch.
- Vertical regions of v_cnt: same layout. vsync=1 for whole lines v_cnt in [V_SIZE+V_FRONT, V_SIZE+V_FRONT+V_SYNC-1].
- de=1 iff h_cnt<H_SIZE and v_cnt<V_SIZE.
- hsync toggles on every line, including vertical blanking lines.
- States:
  - IDLE: counters held at 0; all outputs 0.
  - RUN: h_cnt increments each cycle and wraps at H_TOTAL-1 to 0, incrementing v_cnt; v_cnt wraps at V_TOTAL-1 to 0.
- Transitions:
  - IDLE->RUN when en=1 at a clock edge; counters enter RUN at (0,0).
  - RUN->IDLE only at the frame's last cycle (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) if en=0 there. Deasserting en mid-frame never truncates a frame.
  - RUN with en=1 at the last cycle continues to (0,0) with no gap.
- Pattern latching:
  - pattern is latched into pat_q on IDLE->RUN and at every frame wrap to (0,0).
  - Changes mid-frame take effect next frame.
- Pixel functions, on the counters:
  - 0 -> binary=0
  - 1 -> binary=1
  - 2 -> binary = h_cnt[2] XOR v_cnt[2] (4x4 squares)
  - 3 -> binary=1 iff h_cnt[2:0]=3 and v_cnt[2:0]=3 (single isolated pixels; a 5x5 median output must be all 0)
  - binary is forced to 0 whenever de=0.
- Output timing:
  - All outputs are registered from the counter state: output for counter (h,v) appears one cycle after the counters hold (h,v).
  - x/y equal the counter values of that pixel.
  - First de=1 is two rising edges after the edge that samples en=1 in IDLE.
- frame_start = 1 exactly in the output cycle where x=0, y=0.
- Reset:
  - rst=1 forces IDLE, counters 0, pat_q=0, and all outputs 0 on the next edge.
  - Applies mid-frame too; there is no partial-frame resumption after reset.
- Sync, de and binary stay mutually aligned with zero skew.

Decomposition:
- Shared package skin_pkg:
  - pattern encodings PAT_ZERO=0, PAT_ONE=1, PAT_CHECK=2, PAT_DOTS=3
  - 10-bit coordinate width constant
  - state encodings IDLE/RUN
- Sub-module: frame_timing_gen (h/v counters, region decode for de/hsync/vsync).
- binary_frame_tx adds en/state control, pattern latching and the pixel function.

Test Plan:
- Reset mid-frame at output (40,10) -> next cycle all outputs 0; with en=1 after reset release, frame_start reappears and de first rises 2 edges after en is sampled.
- Defaults, en=1, pattern=1, one frame -> 64 lines × 83 de-cycles = 5312 binary=1 pixels. hsync high for 8 cycles per line starting at x=87, 70 times per frame. vsync high for lines y=66..67. frame_start period 7210 cycles.
- pattern=2 -> pixel (4,0)=1, (0,0)=0, (4,4)=0, (0,4)=1; binary=0 at every de=0 cycle.
- pattern=3 -> ones exactly at (3,3), (11,3), ..., (83 excluded); 10 ones per dotted line × 8 dotted lines = 80 per frame.
- pattern changed 0->1 at (20,30) mid-frame -> binary stays 0 until the next frame_start, then is 1 from pixel (0,0).
- en dropped at (10,5) -> frame completes through (102,69), then outputs go 0 and stay idle. en reasserted -> new frame starts at (0,0) with frame_start pulse.
